// File: rtl/trig_pkg.sv
// Shared types and constants for the line-trigger scheduler.
package trig_pkg;

  // Default widths
  localparam int CNT_W_DEF   = 32;
  localparam int PULSE_W_DEF = 4;
  localparam int OVR_W_DEF   = 16;

  // Line-event source selection codes
  localparam logic [1:0] SRC_ENC   = 2'd0;
  localparam logic [1:0] SRC_SOFT  = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_NONE  = 2'd3;

  // Scheduler states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_ARMED  = 3'd2,
    S_DELAY  = 3'd3,
    S_ACTIVE = 3'd4,
    S_DONE   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/line_trigger_sched_if.sv
// Register, event and status bundle between the register bank / event
// sources (master) and the line-trigger scheduler (slave).
interface line_trigger_sched_if
  import trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OVR_W = OVR_W_DEF
);
  logic             reg_sched_en;
  logic [1:0]       reg_src_sel;
  logic             reg_frame_mode;
  logic [CNT_W-1:0] reg_line_period;
  logic [CNT_W-1:0] reg_min_interval;
  logic [CNT_W-1:0] reg_frame_delay;
  logic [CNT_W-1:0] reg_line_num;
  logic             frame_start;
  logic             encoder_pulse;
  logic             soft_trigger;
  logic             line_trigger;
  logic             frame_busy;
  logic             frame_done;
  logic             frame_miss;
  logic [CNT_W-1:0] line_cnt;
  logic [OVR_W-1:0] overrun_cnt;

  modport master (
    output reg_sched_en, reg_src_sel, reg_frame_mode, reg_line_period,
           reg_min_interval, reg_frame_delay, reg_line_num,
           frame_start, encoder_pulse, soft_trigger,
    input  line_trigger, frame_busy, frame_done, frame_miss, line_cnt, overrun_cnt
  );

  modport slave (
    input  reg_sched_en, reg_src_sel, reg_frame_mode, reg_line_period,
           reg_min_interval, reg_frame_delay, reg_line_num,
           frame_start, encoder_pulse, soft_trigger,
    output line_trigger, frame_busy, frame_done, frame_miss, line_cnt, overrun_cnt
  );
endinterface

// File: rtl/trig_period_gen.sv
// Internal line timer: counts 0..period-1 while enabled and pulses tick on
// the terminal count. A period of zero keeps the timer silent.
module trig_period_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic             term;

  // >= rather than == so a live period reduction below the count still wraps
  assign term = (period != '0) && (cnt >= period - CNT_W'(1));
  assign tick = en && term;

  // Free-running period counter, held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      cnt <= '0;
    end else if (!en || period == '0 || term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/line_trigger_sched.sv
// Per-frame line-trigger scheduler: picks a line-event source, applies a
// minimum-interval guard, sequences gated frames (arm, skip, emit, done) and
// stretches each emitted line into a fixed-width line_trigger pulse.
module line_trigger_sched
  import trig_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int OVR_W   = OVR_W_DEF
) (
  input logic                clk,
  input logic                rst,
  line_trigger_sched_if.slave bus
);
  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_RUN    = S_RUN;
  localparam logic [2:0] ST_ARMED  = S_ARMED;
  localparam logic [2:0] ST_DELAY  = S_DELAY;
  localparam logic [2:0] ST_ACTIVE = S_ACTIVE;
  localparam logic [2:0] ST_DONE   = S_DONE;

  localparam int WCW = $clog2(PULSE_W + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] guard_q;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W-1:0] line_cnt_q;
  logic [OVR_W-1:0] ovr_q;
  logic [WCW-1:0]   wcnt_q;
  logic             miss_q;

  logic en;
  logic tick;
  logic evt;
  logic accept;
  logic emit;
  logic cnt_clr;
  logic dly_clr;
  logic dly_inc;

  assign en = bus.reg_sched_en;

  trig_period_gen #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en && (state_q != ST_IDLE)),
    .period (bus.reg_line_period),
    .tick   (tick)
  );

  // Line-event source select
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    evt = 1'b0;
    case (bus.reg_src_sel)
      SRC_ENC:   evt = bus.encoder_pulse;
      SRC_SOFT:  evt = bus.soft_trigger;
      SRC_TIMER: evt = tick;
      default:   evt = 1'b0;
    endcase
  end

  assign accept = evt && (guard_q >= bus.reg_min_interval);

  // Frame sequencing: next state plus emit / counter control strobes
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    cnt_clr = 1'b0;
    dly_clr = 1'b0;
    dly_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = bus.reg_frame_mode ? ST_ARMED : ST_RUN;
      end
      ST_RUN: begin
        emit = accept;
      end
      ST_ARMED: begin
        if (bus.frame_start) begin
          cnt_clr = 1'b1;
          dly_clr = 1'b1;
          state_d = (bus.reg_frame_delay != '0) ? ST_DELAY : ST_ACTIVE;
        end
      end
      ST_DELAY: begin
        if (accept) begin
          dly_inc = 1'b1;
          if (dly_q + CNT_W'(1) >= bus.reg_frame_delay) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (bus.reg_line_num == '0) begin
          state_d = ST_DONE;
        end else if (accept) begin
          emit = 1'b1;
          if (line_cnt_q + CNT_W'(1) >= bus.reg_line_num) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_ARMED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      emit    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Guard: cycles since last accept, saturating; parked at all-ones in IDLE
  // so the first event after leaving IDLE is always accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_q <= '0;
    end else if (state_q == ST_IDLE) begin
      guard_q <= '1;
    end else if (accept) begin
      guard_q <= '0;
    end else if (guard_q != '1) begin
      guard_q <= guard_q + CNT_W'(1);
    end
  end

  // Lines discarded so far in the DELAY phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   dly_q <= '0;
    else if (!en || dly_clr)   dly_q <= '0;
    else if (dly_inc)          dly_q <= dly_q + CNT_W'(1);
  end

  // Emitted-line counter (per frame when gated, wrapping total in free-run)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   line_cnt_q <= '0;
    else if (!en || cnt_clr)   line_cnt_q <= '0;
    else if (emit)             line_cnt_q <= line_cnt_q + CNT_W'(1);
  end

  // Saturating count of events rejected by the guard outside IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (!en) begin
      ovr_q <= '0;
    end else if (evt && !accept && (state_q != ST_IDLE) && (ovr_q != '1)) begin
      ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  // Sticky flag: a new frame_start arrived while a frame was still running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= 1'b0;
    end else if (!en) begin
      miss_q <= 1'b0;
    end else if (bus.frame_start && (state_q == ST_DELAY || state_q == ST_ACTIVE)) begin
      miss_q <= 1'b1;
    end
  end

  // Pulse stretcher; a new emit reloads the width so retriggers leave no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wcnt_q <= '0;
    else if (!en)              wcnt_q <= '0;
    else if (emit)             wcnt_q <= WCW'(PULSE_W);
    else if (wcnt_q != '0)     wcnt_q <= wcnt_q - WCW'(1);
  end

  assign bus.line_trigger = (wcnt_q != '0);
  assign bus.frame_busy   = (state_q == ST_DELAY) || (state_q == ST_ACTIVE);
  assign bus.frame_done   = (state_q == ST_DONE);
  assign bus.frame_miss   = miss_q;
  assign bus.line_cnt     = line_cnt_q;
  assign bus.overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_line_trigger_sched.sv
// Self-checking bench for line_trigger_sched: directed scenarios plus random
// segments, compared every cycle against a frame-level behavioural model.
module tb_line_trigger_sched;
  import trig_pkg::*;

  localparam int CW = 32;
  localparam int OW = 16;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_trigger_sched_if #(.CNT_W(CW), .OVR_W(OW)) bus ();

  line_trigger_sched #(.CNT_W(CW), .PULSE_W(PW), .OVR_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: mode, frame phase flags and event timestamps
  int          m_mode;       // -1 idle, 0 free-run, 1 gated
  bit          m_wait, m_skip, m_lines, m_done, m_miss, acc_seen;
  longint      t, t_run, last_acc, last_emit, m_skip_left;
  logic [CW-1:0] m_line_cnt;
  int          m_ovr;
  int          trig_seen, done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_mode = -1; m_wait = 0; m_skip = 0; m_lines = 0; m_done = 0; m_miss = 0;
    m_line_cnt = '0; m_ovr = 0; last_emit = -1000; acc_seen = 0;
  endtask

  task automatic model_step();
    bit evt, tick, acc, emit;
    longint per;
    if (!bus.reg_sched_en) begin
      model_clear();
    end else if (m_mode < 0) begin
      m_mode = bus.reg_frame_mode ? 1 : 0;
      m_wait = bus.reg_frame_mode;
      t_run = t + 1;
      acc_seen = 0;
    end else begin
      per  = longint'(bus.reg_line_period);
      tick = (per != 0) && (((t - t_run) % per) == per - 1);
      case (bus.reg_src_sel)
        2'd0:    evt = bus.encoder_pulse;
        2'd1:    evt = bus.soft_trigger;
        2'd2:    evt = tick;
        default: evt = 1'b0;
      endcase
      acc = evt && (!acc_seen || (t - last_acc - 1) >= longint'(bus.reg_min_interval));
      if (acc) begin
        acc_seen = 1;
        last_acc = t;
      end else if (evt && m_ovr < 65535) begin
        m_ovr++;
      end
      emit = 0;
      if (m_mode == 0) begin
        emit = acc;
        if (acc) m_line_cnt++;
      end else if (m_done) begin
        m_done = 0;
        m_wait = 1;
      end else if (m_wait) begin
        if (bus.frame_start) begin
          m_wait = 0;
          m_line_cnt = '0;
          m_skip_left = longint'(bus.reg_frame_delay);
          if (m_skip_left == 0) m_lines = 1;
          else m_skip = 1;
        end
      end else begin
        if (bus.frame_start) m_miss = 1;
        if (m_skip) begin
          if (acc) begin
            m_skip_left--;
            if (m_skip_left == 0) begin
              m_skip = 0;
              m_lines = 1;
            end
          end
        end else if (m_lines) begin
          if (bus.reg_line_num == '0) begin
            m_lines = 0;
            m_done = 1;
          end else if (acc) begin
            emit = 1;
            m_line_cnt++;
            if (m_line_cnt == bus.reg_line_num) begin
              m_lines = 0;
              m_done = 1;
            end
          end
        end
      end
      if (emit) last_emit = t;
    end
    t++;
  endtask

  task automatic check_all();
    logic exp_trig;
    exp_trig = ((t - last_emit) >= 1) && ((t - last_emit) <= PW);
    chk({phase, " line_trigger"}, 64'(bus.line_trigger), 64'(exp_trig));
    chk({phase, " frame_busy"},   64'(bus.frame_busy),   64'(m_skip || m_lines));
    chk({phase, " frame_done"},   64'(bus.frame_done),   64'(m_done));
    chk({phase, " frame_miss"},   64'(bus.frame_miss),   64'(m_miss));
    chk({phase, " line_cnt"},     64'(bus.line_cnt),     64'(m_line_cnt));
    chk({phase, " overrun_cnt"},  64'(bus.overrun_cnt),  64'(m_ovr));
  endtask

  // One clock: advance model with current inputs, clock DUT, compare, drop pulses
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (bus.line_trigger) trig_seen++;
    if (bus.frame_done)   done_seen++;
    bus.frame_start   = 1'b0;
    bus.encoder_pulse = 1'b0;
    bus.soft_trigger  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_regs(input logic mode, input logic [1:0] src, input int per,
                          input int min_iv, input int dly, input int num);
    bus.reg_frame_mode   = mode;
    bus.reg_src_sel      = src;
    bus.reg_line_period  = CW'(per);
    bus.reg_min_interval = CW'(min_iv);
    bus.reg_frame_delay  = CW'(dly);
    bus.reg_line_num     = CW'(num);
  endtask

  initial begin
    rst = 1'b1;
    bus.reg_sched_en  = 1'b0;
    bus.frame_start   = 1'b0;
    bus.encoder_pulse = 1'b0;
    bus.soft_trigger  = 1'b0;
    set_regs(1'b0, SRC_NONE, 0, 0, 0, 0);
    model_clear();
    t = 0;
    trig_seen = 0;
    done_seen = 0;

    // Reset state
    #12;
    phase = "reset";
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: free-run internal timer, period 10
    phase = "t1";
    set_regs(1'b0, SRC_TIMER, 10, 0, 0, 0);
    bus.reg_sched_en = 1'b1;
    trig_seen = 0;
    run(60);
    chk("t1 lines", 64'(bus.line_cnt), 64'd5);
    chk("t1 trig_cycles", 64'(trig_seen), 64'd20);
    bus.reg_sched_en = 1'b0;
    run(2);

    // T3: guard min=15, encoder at 0, 5, 20
    phase = "t3";
    set_regs(1'b0, SRC_ENC, 0, 15, 0, 0);
    bus.reg_sched_en = 1'b1;
    step();
    trig_seen = 0;
    bus.encoder_pulse = 1'b1; step();
    run(4);
    bus.encoder_pulse = 1'b1; step();
    run(14);
    bus.encoder_pulse = 1'b1; step();
    run(6);
    chk("t3 overrun", 64'(bus.overrun_cnt), 64'd1);
    chk("t3 lines", 64'(bus.line_cnt), 64'd2);
    chk("t3 trig_cycles", 64'(trig_seen), 64'(2 * PW));
    bus.reg_sched_en = 1'b0;
    run(2);

    // T2: gated, delay 2, num 3, encoder every 20 cycles
    phase = "t2";
    set_regs(1'b1, SRC_ENC, 0, 0, 2, 3);
    bus.reg_sched_en = 1'b1;
    run(3);
    trig_seen = 0;
    done_seen = 0;
    bus.frame_start = 1'b1; step();
    for (int k = 0; k < 6; k++) begin
      run(19);
      bus.encoder_pulse = 1'b1; step();
    end
    run(5);
    chk("t2 lines", 64'(bus.line_cnt), 64'd3);
    chk("t2 done_pulses", 64'(done_seen), 64'd1);
    chk("t2 trig_cycles", 64'(trig_seen), 64'(3 * PW));
    chk("t2 busy_after", 64'(bus.frame_busy), 64'd0);

    // T4: frame_start mid-ACTIVE, then disable clears everything
    phase = "t4";
    set_regs(1'b1, SRC_ENC, 0, 0, 0, 3);
    done_seen = 0;
    bus.frame_start = 1'b1; step();
    run(5);
    bus.encoder_pulse = 1'b1; step();
    run(3);
    bus.frame_start = 1'b1; step();
    chk("t4 miss", 64'(bus.frame_miss), 64'd1);
    run(2);
    bus.encoder_pulse = 1'b1; step();
    run(5);
    bus.encoder_pulse = 1'b1; step();
    run(1);
    chk("t4 lines", 64'(bus.line_cnt), 64'd3);
    chk("t4 done_pulses", 64'(done_seen), 64'd1);
    chk("t4 miss_sticky", 64'(bus.frame_miss), 64'd1);
    bus.reg_sched_en = 1'b0;
    step();
    chk("t4 off trig", 64'(bus.line_trigger), 64'd0);
    chk("t4 off lines", 64'(bus.line_cnt), 64'd0);
    chk("t4 off miss", 64'(bus.frame_miss), 64'd0);
    chk("t4 off busy", 64'(bus.frame_busy), 64'd0);

    // T5: gated with zero lines per frame
    phase = "t5";
    set_regs(1'b1, SRC_ENC, 0, 0, 0, 0);
    bus.reg_sched_en = 1'b1;
    run(2);
    done_seen = 0;
    trig_seen = 0;
    bus.frame_start = 1'b1; step();
    bus.encoder_pulse = 1'b1; step();
    run(4);
    chk("t5 done_pulses", 64'(done_seen), 64'd1);
    chk("t5 trig_cycles", 64'(trig_seen), 64'd0);

    // Random segments
    phase = "rand";
    for (int seg = 0; seg < 8; seg++) begin
      bus.reg_sched_en = 1'b0;
      step();
      set_regs(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      bus.reg_sched_en = 1'b1;
      for (int c = 0; c < 250; c++) begin
        bus.frame_start   = ($urandom_range(0, 39) == 0);
        bus.encoder_pulse = ($urandom_range(0, 3) == 0);
        bus.soft_trigger  = ($urandom_range(0, 4) == 0);
        step();
      end
    end

    // T6: async reset mid-pulse in ACTIVE
    phase = "t6";
    bus.reg_sched_en = 1'b0;
    step();
    set_regs(1'b1, SRC_SOFT, 0, 0, 0, 5);
    bus.reg_sched_en = 1'b1;
    run(2);
    bus.frame_start = 1'b1; step();
    run(2);
    bus.soft_trigger = 1'b1; step();
    step();
    rst = 1'b1;
    #1;
    chk("t6 rst trig", 64'(bus.line_trigger), 64'd0);
    chk("t6 rst lines", 64'(bus.line_cnt), 64'd0);
    chk("t6 rst busy", 64'(bus.frame_busy), 64'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    run(5);
    chk("t6 post busy", 64'(bus.frame_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
